// File: rtl/shift_sequencer_if.sv
// Request/response and shift-unit bundle for shift_sequencer.
//   Request side : START, OPCODE, DATA, AMOUNT in; BUSY, DONE, RESULT out.
//   Shift unit   : SH_IN, SH_OP, SH_AMT out; SH_OUT in.
// modport slave is the sequencer's view. modport master is the view of the
// requester and the shift unit together.
interface shift_sequencer_if #(
  parameter int unsigned AMT_W = 8
);
  logic             START;
  logic [1:0]       OPCODE;
  logic [7:0]       DATA;
  logic [AMT_W-1:0] AMOUNT;
  logic             BUSY;
  logic             DONE;
  logic [7:0]       RESULT;
  logic [7:0]       SH_IN;
  logic [1:0]       SH_OP;
  logic [2:0]       SH_AMT;
  logic [7:0]       SH_OUT;

  modport slave (
    input  START, OPCODE, DATA, AMOUNT, SH_OUT,
    output BUSY, DONE, RESULT, SH_IN, SH_OP, SH_AMT
  );

  modport master (
    output START, OPCODE, DATA, AMOUNT, SH_OUT,
    input  BUSY, DONE, RESULT, SH_IN, SH_OP, SH_AMT
  );
endinterface

// File: rtl/shift_sequencer.sv
// Multi-cycle shift/rotate sequencer. It splits an 8-bit shift amount
// (0..255) into passes of at most MAX_STEP positions through an external
// single-pass barrel shifter, and feeds each partial result back.
// Ports:
//   CLK   : clock, rising edge
//   RESET : asynchronous active-high reset
//   bus   : shift_sequencer_if.slave, which carries START/OPCODE/DATA/AMOUNT
//           in, BUSY/DONE/RESULT out, SH_IN/SH_OP/SH_AMT out to the shift
//           unit, and SH_OUT back from it
// Optional build macro: SHIFT_SEQ_EARLY_EXIT_EN. When it is defined, SLL and
// SRL with AMOUNT>=8 and SRA with AMOUNT>=7 complete without any shift pass.
module shift_sequencer #(
  parameter int unsigned MAX_STEP = 7,
  parameter int unsigned AMT_W    = 8
) (
  input logic                CLK,
  input logic                RESET,
  shift_sequencer_if.slave   bus
);

  localparam logic [1:0] OpSll = 2'b00;
  localparam logic [1:0] OpSrl = 2'b01;
  localparam logic [1:0] OpSra = 2'b10;
  localparam logic [1:0] OpRor = 2'b11;

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e     state_q, state_d;
  logic [7:0] acc_q, acc_d;
  logic [3:0] rem_q, rem_d;
  logic [1:0] op_q, op_d;
  logic [7:0] result_q, result_d;

  logic [3:0] eff;
  logic [2:0] step;
  logic       amt_ge8;

  // A shift of 8 or more clears or sign-fills the value. Clamp such amounts
  // to 8 so that rem fits in 4 bits. A rotate only needs the amount mod 8.
  assign amt_ge8 = (bus.AMOUNT >= AMT_W'(8));
  assign eff     = (bus.OPCODE == OpRor) ? {1'b0, bus.AMOUNT[2:0]} :
                   amt_ge8               ? 4'd8 : bus.AMOUNT[3:0];
  assign step    = (rem_q > 4'(MAX_STEP)) ? 3'(MAX_STEP) : rem_q[2:0];

`ifdef SHIFT_SEQ_EARLY_EXIT_EN
  logic       early_hit;
  logic [7:0] early_val;
  // SRA by 7 or more already gives pure sign fill, so it counts as saturated.
  always_comb begin
    early_hit = 1'b0;
    early_val = 8'h00;
    if ((bus.OPCODE == OpSll || bus.OPCODE == OpSrl) && amt_ge8) begin
      early_hit = 1'b1;
    end else if (bus.OPCODE == OpSra && bus.AMOUNT >= AMT_W'(7)) begin
      early_hit = 1'b1;
      early_val = {8{bus.DATA[7]}};
    end
  end
`endif

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    rem_d    = rem_q;
    op_d     = op_q;
    result_d = result_q;
    unique case (state_q)
      StIdle: begin
        if (bus.START) begin
          op_d  = bus.OPCODE;
          acc_d = bus.DATA;
          rem_d = eff;
          if (eff == 4'd0) begin
            state_d  = StDone;
            result_d = bus.DATA;
          end else begin
            state_d = StShift;
          end
`ifdef SHIFT_SEQ_EARLY_EXIT_EN
          if (early_hit) begin
            acc_d    = early_val;
            rem_d    = 4'd0;
            state_d  = StDone;
            result_d = early_val;
          end
`endif
        end
      end
      StShift: begin
        acc_d = bus.SH_OUT;
        rem_d = rem_q - {1'b0, step};
        if (rem_d == 4'd0) begin
          state_d  = StDone;
          result_d = bus.SH_OUT;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q  <= StIdle;
      acc_q    <= 8'h00;
      rem_q    <= 4'd0;
      op_q     <= OpSll;
      result_q <= 8'h00;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      rem_q    <= rem_d;
      op_q     <= op_d;
      result_q <= result_d;
    end
  end

  assign bus.BUSY   = (state_q != StIdle);
  assign bus.DONE   = (state_q == StDone);
  assign bus.RESULT = result_q;
  assign bus.SH_IN  = acc_q;
  assign bus.SH_OP  = op_q;
  assign bus.SH_AMT = (state_q == StShift) ? step : 3'd0;

  // OpSrl is named only to document the encoding.
  logic unused_op;
  assign unused_op = ^OpSrl;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer. It models the external barrel shifter
// with a 2-time-unit delay and checks handshake timing, pass amounts and
// results. Inputs are driven on the falling edge or just after the rising
// edge, and outputs are sampled on the falling edge.
module tb_shift_sequencer;

  logic clk;
  logic rst;
  int   n_assert;
  int   n_fail;
  int   cyc;

  shift_sequencer_if #(.AMT_W(8)) bus ();

  shift_sequencer #(
    .MAX_STEP(7),
    .AMT_W   (8)
  ) dut (
    .CLK  (clk),
    .RESET(rst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference barrel shifter. It handles one pass of 0..7 positions.
  function automatic logic [7:0] shf(input logic [7:0] d, input logic [1:0] op,
                                     input logic [2:0] amt);
    logic [15:0] dd;
    dd = {d, d};
    case (op)
      2'b00:   shf = d << amt;
      2'b01:   shf = d >> amt;
      2'b10:   shf = 8'($signed(d) >>> amt);
      default: shf = dd[7:0] >> 0 == 8'h00 ? 8'h00 : 8'(dd >> amt);
    endcase
  endfunction

  assign #2 bus.SH_OUT = shf(bus.SH_IN, bus.SH_OP, bus.SH_AMT);

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pulse START for one rising edge (E0). Returns 1 time unit after E0.
  task automatic start_job(input logic [1:0] op, input logic [7:0] d, input logic [7:0] amt);
    @(negedge clk);
    bus.START  = 1'b1;
    bus.OPCODE = op;
    bus.DATA   = d;
    bus.AMOUNT = amt;
    @(posedge clk);
    #1;
    bus.START = 1'b0;
  endtask

  // Count falling edges until DONE is seen. limit+1 means it never came.
  task automatic wait_done(input int limit, output int cycles);
    cycles = limit + 1;
    for (int i = 1; i <= limit; i++) begin
      @(negedge clk);
      if (bus.DONE === 1'b1) begin
        cycles = i;
        break;
      end
    end
  endtask

`ifdef SHIFT_SEQ_EARLY_EXIT_EN
  localparam int EarlyOn = 1;
`else
  localparam int EarlyOn = 0;
`endif

  initial begin
    n_assert   = 0;
    n_fail     = 0;
    rst        = 1'b1;
    bus.START  = 1'b0;
    bus.OPCODE = 2'b00;
    bus.DATA   = 8'h00;
    bus.AMOUNT = 8'h00;
    #3;
    chk("rst_busy", {7'd0, bus.BUSY}, 8'd0);
    chk("rst_done", {7'd0, bus.DONE}, 8'd0);
    chk("rst_result", bus.RESULT, 8'h00);
    chk("rst_sh_amt", {5'd0, bus.SH_AMT}, 8'd0);
    @(negedge clk);
    rst = 1'b0;

    // SLL 0x5A by 0: no pass, DONE in the cycle after E0.
    start_job(2'b00, 8'h5A, 8'd0);
    @(negedge clk);
    chk("sll0_done", {7'd0, bus.DONE}, 8'd1);
    chk("sll0_sh_amt", {5'd0, bus.SH_AMT}, 8'd0);
    chk("sll0_result", bus.RESULT, 8'h5A);
    @(negedge clk);
    chk("sll0_busy_after", {7'd0, bus.BUSY}, 8'd0);
    chk("sll0_done_after", {7'd0, bus.DONE}, 8'd0);

    // SRL 0xF0 by 12, with a second START while busy that must be dropped.
    start_job(2'b01, 8'hF0, 8'd12);
    @(negedge clk);
    chk("srl_busy", {7'd0, bus.BUSY}, 8'd1);
    chk("srl_done_n1", {7'd0, bus.DONE}, 8'(EarlyOn));
    if (EarlyOn == 0) chk("srl_pass1", {5'd0, bus.SH_AMT}, 8'd7);
    bus.START  = 1'b1;
    bus.OPCODE = 2'b00;
    bus.DATA   = 8'hFF;
    bus.AMOUNT = 8'd1;
    @(posedge clk);
    #1;
    bus.START = 1'b0;
    if (EarlyOn == 0) begin
      wait_done(10, cyc);
      chk("srl_lat_rest", 8'(cyc), 8'd2);
    end
    chk("srl_result", bus.RESULT, 8'h00);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("srl_no_requeue_done", {7'd0, bus.DONE}, 8'd0);
      chk("srl_no_requeue_busy", {7'd0, bus.BUSY}, 8'd0);
    end
    chk("srl_result_held", bus.RESULT, 8'h00);

    // SRA 0x99 by 3: one pass of 3, result 0xF3.
    start_job(2'b10, 8'h99, 8'd3);
    @(negedge clk);
    chk("sra3_sh_amt", {5'd0, bus.SH_AMT}, 8'd3);
    chk("sra3_sh_in", bus.SH_IN, 8'h99);
    chk("sra3_sh_op", {6'd0, bus.SH_OP}, 8'd2);
    chk("sra3_done_early", {7'd0, bus.DONE}, 8'd0);
    @(negedge clk);
    chk("sra3_done", {7'd0, bus.DONE}, 8'd1);
    chk("sra3_result", bus.RESULT, 8'hF3);
    chk("sra3_sh_amt_done", {5'd0, bus.SH_AMT}, 8'd0);

    // SLL 0x81 by 10: passes of 7 then 1 (unless early exit applies).
    start_job(2'b00, 8'h81, 8'd10);
    if (EarlyOn == 0) begin
      @(negedge clk);
      chk("sll10_pass1", {5'd0, bus.SH_AMT}, 8'd7);
      @(negedge clk);
      chk("sll10_pass2", {5'd0, bus.SH_AMT}, 8'd1);
      chk("sll10_acc", bus.SH_IN, 8'h80);
      wait_done(10, cyc);
      chk("sll10_lat", 8'(cyc), 8'd1);
    end else begin
      wait_done(10, cyc);
      chk("sll10_lat", 8'(cyc), 8'd1);
    end
    chk("sll10_result", bus.RESULT, 8'h00);

    // SRA 0x80 by 200: sign fill to 0xFF.
    start_job(2'b10, 8'h80, 8'd200);
    wait_done(10, cyc);
    chk("sra200_lat", 8'(cyc), EarlyOn != 0 ? 8'd1 : 8'd3);
    chk("sra200_result", bus.RESULT, 8'hFF);

    // ROR 0xC3 by 11: amount 3 after mod 8, result 0x78.
    start_job(2'b11, 8'hC3, 8'd11);
    @(negedge clk);
    chk("ror11_sh_amt", {5'd0, bus.SH_AMT}, 8'd3);
    wait_done(10, cyc);
    chk("ror11_lat", 8'(cyc), 8'd1);
    chk("ror11_result", bus.RESULT, 8'h78);

    // Asynchronous reset in the middle of a SHIFT pass.
    start_job(2'b00, 8'h81, 8'd7);
    @(negedge clk);
    chk("mid_busy", {7'd0, bus.BUSY}, 8'd1);
    chk("mid_sh_amt", {5'd0, bus.SH_AMT}, 8'd7);
    #1;
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", {7'd0, bus.BUSY}, 8'd0);
    chk("mid_rst_done", {7'd0, bus.DONE}, 8'd0);
    chk("mid_rst_result", bus.RESULT, 8'h00);
    chk("mid_rst_sh_amt", {5'd0, bus.SH_AMT}, 8'd0);
    chk("mid_rst_sh_in", bus.SH_IN, 8'h00);
    chk("mid_rst_sh_op", {6'd0, bus.SH_OP}, 8'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_rst_done", {7'd0, bus.DONE}, 8'd0);
      chk("post_rst_busy", {7'd0, bus.BUSY}, 8'd0);
    end

    // The block must accept new work after the reset.
    start_job(2'b01, 8'hF0, 8'd3);
    wait_done(10, cyc);
    chk("recover_lat", 8'(cyc), 8'd2);
    chk("recover_result", bus.RESULT, 8'h1E);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/shift_sequencer.md
Name: shift_sequencer

Overview:
- Multi-cycle controller that runs an 8-bit shift or rotate by any 8-bit amount (0..255) through the ALU's single-pass barrel shift unit.
- The shift unit handles only 0..7 positions per pass, so this block splits the requested amount into passes and feeds each partial result back.
- Sits between the instruction control unit (START/DONE handshake) and the shift datapath.

Parameters:
- MAX_STEP, 7, maximum positions per pass driven on SH_AMT; legal range 1..7.
- AMT_W, 8, width of the AMOUNT request field.

Ports:
- CLK  input  1  system clock, rising edge.
- RESET  input  1  asynchronous, active-high reset.
- START  input  1  request strobe; sampled only in IDLE.
- OPCODE  input  2  shift type: 00 SLL, 01 SRL, 10 SRA, 11 ROR.
- DATA  input  8  operand, captured on accept.
- AMOUNT  input  AMT_W  requested shift count, captured on accept.
- BUSY  output  1  high whenever state is not IDLE.
- DONE  output  1  one-cycle completion pulse.
- RESULT  output  8  final value; held until the next completion.
- SH_IN  output  8  operand to the shift unit (the internal accumulator).
- SH_OP  output  2  shift type to the shift unit (the latched OPCODE).
- SH_AMT  output  3  positions for the current pass; 0 outside SHIFT.
- SH_OUT  input  8  shift unit result; must settle within one CLK period (the unit has a 2-time-unit delay).

Behaviour:
- Reset (asynchronous, any time, including mid-operation):
  - state=IDLE; BUSY=0, DONE=0, RESULT=8'h00, SH_AMT=0.
  - Accumulator, remaining count and latched opcode all cleared.
- Effective amount EFF, computed at accept:
  - ROR: AMOUNT mod 8.
  - SLL, SRL, SRA: min(AMOUNT, 8).
- States:
  - IDLE: on an edge with START=1, latch OPCODE, load accumulator=DATA, rem=EFF. Go to SHIFT if EFF>0, else DONE.
  - SHIFT: step=min(rem, MAX_STEP) is driven on SH_AMT combinationally. Each edge: accumulator<=SH_OUT, rem<=rem-step. Go to DONE when rem-step==0, else stay in SHIFT.
  - DONE: DONE=1 for exactly one cycle. RESULT is loaded with the accumulator on the edge entering DONE. Next state is IDLE.
- Latency: accept edge E0, then N=ceil(EFF/MAX_STEP) SHIFT edges. DONE is high during the cycle after edge E(N), which is E0 when EFF=0.
- START in SHIFT or DONE: ignored, not queued. The requester must re-issue it after BUSY falls.
- SH_IN always equals the accumulator. SH_OP always equals the latched opcode.
- SRA fill comes from the accumulator's bit 7 on every pass, so the sign is preserved across passes.
- Arithmetic: rem is 4 bits wide (max 8) and never underflows.

Optional Feature:
- Macro: SHIFT_SEQ_EARLY_EXIT_EN.
- Defined:
  - SLL/SRL with AMOUNT>=8 skips SHIFT and goes straight to DONE with result 8'h00.
  - SRA with AMOUNT>=7 skips SHIFT with result {8{DATA[7]}}.
  - In both cases DONE is high in the cycle after E0.
- Not defined: these cases iterate normally through SHIFT; results are identical and only latency differs.

Test Plan:
- SRA, DATA=8'b10011001, AMOUNT=3 -> one SHIFT pass with SH_AMT=3; RESULT=8'b11110011; DONE in the cycle after E1.
- ROR, DATA=8'hC3, AMOUNT=11 -> EFF=3; RESULT=8'h78; one pass.
- SLL, DATA=8'h81, AMOUNT=10 -> passes SH_AMT=7 then 1; RESULT=8'h00; DONE after E2.
  - With SHIFT_SEQ_EARLY_EXIT_EN: DONE after E0.
- SRA, DATA=8'h80, AMOUNT=200 -> passes 7 then 1; RESULT=8'hFF.
  - With SHIFT_SEQ_EARLY_EXIT_EN: no passes.
- SLL, DATA=8'h5A, AMOUNT=0 -> no SHIFT; RESULT=8'h5A; DONE in the cycle after E0; SH_AMT stays 0.
- SRL, DATA=8'hF0, AMOUNT=12:
  - START re-pulsed while BUSY -> ignored; RESULT=8'h00.
  - New job started, then RESET asserted between edges mid-SHIFT -> BUSY=0, DONE=0, RESULT=8'h00 immediately, with no DONE pulse.
